// File: rtl/regfile_write_arbiter.sv
// Register-file write-port master: merges ALU and load writebacks, buffers load
// returns in a small FIFO with an anti-starvation age counter, and tracks pending loads.
module regfile_write_arbiter #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2,
    parameter int AGE_MAX  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            we,
    output logic [4:0]      wa,
    output logic [XLEN-1:0] wd,
    output logic [31:0]     busy
);

    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    logic [4:0]      rd_mem   [LQ_DEPTH];
    logic [XLEN-1:0] data_mem [LQ_DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg,  count_next;
    logic [AGE_W-1:0] age_reg,    age_next;

    logic            we_reg;
    logic [4:0]      wa_reg;
    logic [XLEN-1:0] wd_reg;
    logic [31:1]     busy_reg;

    logic            head_present;
    logic            head_forced;
    logic            alu_win;
    logic            deq;
    logic            enq;
    logic            win_any;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;

    // Handshake-ready signals depend on registered state only.
    assign head_present = (count_reg != '0);
    assign head_forced  = head_present && (age_reg == AGE_W'(AGE_MAX));
    assign alu_ready    = !head_forced;
    assign ld_ready     = (count_reg < CNT_W'(LQ_DEPTH));

    assign alu_win = alu_valid && !head_forced;
    assign deq     = !alu_win && head_present;
    assign enq     = ld_valid && ld_ready;
    assign win_any = alu_win || deq;

    assign head_rd   = rd_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];

    always_comb begin
        win_rd   = head_rd;
        win_data = head_data;
        if (alu_win) begin
            win_rd   = alu_rd;
            win_data = alu_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (enq && !deq) begin
            count_next = count_reg + CNT_W'(1);
        end else if (deq && !enq) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_comb begin
        age_next = age_reg;
        if (deq || !head_present) begin
            age_next = '0;
        end else if (age_reg != AGE_W'(AGE_MAX)) begin
            age_next = age_reg + AGE_W'(1);
        end
    end

    // Payload storage carries no reset; validity is tracked by count_reg.
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[wr_ptr_reg]   <= ld_rd;
            data_mem[wr_ptr_reg] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            age_reg    <= '0;
        end else begin
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            age_reg   <= age_next;
        end
    end

    // wa/wd hold their last value when there is no winner; x0 writes suppress we.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_reg <= 1'b0;
            wa_reg <= '0;
            wd_reg <= '0;
        end else begin
            we_reg <= win_any && (win_rd != 5'd0);
            if (win_any) begin
                wa_reg <= win_rd;
                wd_reg <= win_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            // A new issue to the same register outranks the returning load's clear.
            always_ff @(posedge clk) begin
                if (reset) begin
                    busy_reg[gi] <= 1'b0;
                end else if (issue_valid && (issue_rd == 5'(gi))) begin
                    busy_reg[gi] <= 1'b1;
                end else if (deq && (head_rd == 5'(gi))) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign we   = we_reg;
    assign wa   = wa_reg;
    assign wd   = wd_reg;
    assign busy = {busy_reg, 1'b0};

endmodule
